// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
package regfile_pkg;

    localparam int ZERO_REG    = 0;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_NRD     = 2;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-write bit per register, set at issue, cleared at writeback, wiped on flush.
// REGFILE_BYPASS_EN makes a same-cycle clearing write visible on the busy outputs.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int NRD    = DEF_NRD,
    localparam int ADDR_W = addr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_aw,
    input  logic                  i_res_en,
    input  logic [ADDR_W-1:0]     i_res_a,
    input  logic                  i_flush,
    input  logic [NRD*ADDR_W-1:0] i_ar,
    output logic [NRD-1:0]        o_busy,
    output logic                  o_err
);

    logic [DEPTH-1:0] r_busy;
    logic             r_err;
    logic             w_clr;
    logic             w_set;
    logic             w_waw;

    assign w_clr = i_we && (i_aw != ADDR_W'(ZERO_REG));
    assign w_set = i_res_en && (i_res_a != ADDR_W'(ZERO_REG)) && !i_flush;
    // A busy target is only a hazard if the write releasing it is not landing this same cycle.
    assign w_waw = w_set && r_busy[i_res_a] && !(w_clr && (i_aw == i_res_a));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_waw;
            if (i_flush) begin
                r_busy <= '0;
            end else begin
                if (w_clr) r_busy[i_aw] <= 1'b0;
                if (w_set) r_busy[i_res_a] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            o_busy[i] = r_busy[i_ar[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (w_clr && (i_ar[i*ADDR_W +: ADDR_W] == i_aw))
                o_busy[i] = w_set && (i_res_a == i_aw);
`endif
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file (x0 hardwired to zero) with busy scoreboard.
// REGFILE_BYPASS_EN forwards same-cycle writeback data onto matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int NRD    = DEF_NRD,
    localparam int ADDR_W = addr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_aw,
    input  logic [WIDTH-1:0]      i_d,
    input  logic [NRD*ADDR_W-1:0] i_ar,
    output logic [NRD*WIDTH-1:0]  o_q,
    output logic [NRD-1:0]        o_busy,
    input  logic                  i_res_en,
    input  logic [ADDR_W-1:0]     i_res_a,
    input  logic                  i_flush,
    output logic                  o_err
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;

    assign w_wr = i_we && (i_aw != ADDR_W'(ZERO_REG));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_aw] <= i_d;
        end
    end

    always_comb begin
        o_q = '0;
        for (int i = 0; i < NRD; i++) begin
            if (i_ar[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                o_q[i*WIDTH +: WIDTH] = r_mem[i_ar[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (w_wr && (i_ar[i*ADDR_W +: ADDR_W] == i_aw))
                o_q[i*WIDTH +: WIDTH] = i_d;
`endif
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_we     (i_we),
        .i_aw     (i_aw),
        .i_res_en (i_res_en),
        .i_res_a  (i_res_a),
        .i_flush  (i_flush),
        .i_ar     (i_ar),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

endmodule
